// File: rtl/mdu_param.sv
// Parametrised multiply/divide unit for the E stage: HI/LO registers, fixed-latency
// multiply/MAC/MSUB and divide with a busy window, flush cancel and mthi/mtlo.
module mdu_param #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam int W2      = 2 * WIDTH;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_res_hi;
  logic [WIDTH-1:0] r_res_lo;

  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  // Magnitude of a signed operand; the most-negative value maps to 2^(WIDTH-1)
  // as an unsigned number, which keeps the overflow case exact.
  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? f_neg(v) : v;
  endfunction

  logic             w_signed;
  logic             w_is_mul;
  logic             w_is_div;
  logic [W2-1:0]    w_a_ext;
  logic [W2-1:0]    w_b_ext;
  logic [W2-1:0]    w_prod;
  logic [W2-1:0]    w_acc;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH-1:0] w_div_b;
  logic [WIDTH-1:0] w_q_mag;
  logic [WIDTH-1:0] w_r_mag;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_r;
  logic [W2-1:0]    w_res;

  assign w_signed = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  assign w_is_mul = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
                    (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  assign w_is_div = (op == OP_DIV) || (op == OP_DIVU);

  // Sign/zero extension to 2*WIDTH makes the truncated product exact for both classes.
  assign w_a_ext = w_signed ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
  assign w_b_ext = w_signed ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
  assign w_prod  = w_a_ext * w_b_ext;
  assign w_acc   = {hi, lo};

  assign w_mag_a = f_mag(src_a, w_signed);
  assign w_mag_b = f_mag(src_b, w_signed);
  assign w_div_b = (src_b == '0) ? WIDTH'(1) : w_mag_b;
  assign w_q_mag = w_mag_a / w_div_b;
  assign w_r_mag = w_mag_a % w_div_b;
  assign w_q     = (w_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1])) ? f_neg(w_q_mag) : w_q_mag;
  assign w_r     = (w_signed && src_a[WIDTH-1]) ? f_neg(w_r_mag) : w_r_mag;

  always_comb begin
    w_res = w_acc;
    case (op)
      OP_MULT, OP_MULTU: w_res = w_prod;
      OP_MADD, OP_MADDU: w_res = w_acc + w_prod;
      OP_MSUB, OP_MSUBU: w_res = w_acc - w_prod;
      OP_DIV, OP_DIVU:   w_res = (src_b == '0) ? w_acc : {w_r, w_q};
      default:           w_res = w_acc;
    endcase
  end

  // Priority: reset > flush > commit > start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      busy    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else if (flush) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (op == OP_MTHI) begin
              hi <= src_a;
            end else if (op == OP_MTLO) begin
              lo <= src_a;
            end else if (w_is_mul || w_is_div) begin
              r_res_hi <= w_res[W2-1:WIDTH];
              r_res_lo <= w_res[WIDTH-1:0];
              r_cnt    <= w_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
              r_state  <= RUN;
              busy     <= 1'b1;
            end
          end
        end
        RUN: begin
          if (r_cnt == CNT_W'(1)) begin
            hi      <= r_res_hi;
            lo      <= r_res_lo;
            r_cnt   <= '0;
            r_state <= IDLE;
            busy    <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
